// File: rtl/rob.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rob                                                             |
// | Purpose  : Circular reorder buffer: in-order allocate and commit,          |
// |            out-of-order completion, branch mispredict flush.               |
// | Option   : ROB_CDB_BYPASS_EN forwards the CDB to operand lookups.          |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module rob #(
  parameter int DEPTH = 16,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             disp_valid,
  input  logic [4:0]       disp_rd,
  input  logic             disp_is_br,
  input  logic             disp_pred_taken,
  output logic [IDX_W-1:0] alloc_idx,
  output logic             full,
  input  logic             cdb_valid,
  input  logic [IDX_W-1:0] cdb_idx,
  input  logic [31:0]      cdb_val,
  input  logic             cdb_taken,
  input  logic [31:0]      cdb_target,
  input  logic [IDX_W-1:0] q1_idx,
  input  logic [IDX_W-1:0] q2_idx,
  output logic             q1_ready,
  output logic             q2_ready,
  output logic [31:0]      q1_val,
  output logic [31:0]      q2_val,
  output logic             rf_new_flag,
  output logic [IDX_W-1:0] rf_new_idx,
  output logic [4:0]       rf_new_rd,
  output logic             rf_write_flag,
  output logic [IDX_W-1:0] rf_write_idx,
  output logic [4:0]       rf_write_rd,
  output logic [31:0]      rf_write_val,
  output logic             jump_wrong,
  output logic [31:0]      jump_pc
);

  localparam logic [IDX_W:0]   c_depth   = (IDX_W + 1)'(DEPTH);
  localparam logic [IDX_W:0]   c_cnt_one = (IDX_W + 1)'(1);
  localparam logic [IDX_W-1:0] c_idx_one = IDX_W'(1);

  // Control state (reset)
  logic             r_busy  [DEPTH];
  logic             r_ready [DEPTH];
  logic [IDX_W-1:0] r_head;
  logic [IDX_W-1:0] r_tail;
  logic [IDX_W:0]   r_count;
  logic             r_jump_wrong;
  logic [31:0]      r_jump_pc;

  // Entry payload (no reset needed)
  logic [4:0]       r_rd     [DEPTH];
  logic             r_is_br  [DEPTH];
  logic             r_pred   [DEPTH];
  logic [31:0]      r_val    [DEPTH];
  logic             r_taken  [DEPTH];
  logic [31:0]      r_target [DEPTH];

  logic w_alloc;
  logic w_commit;
  logic w_complete;
  logic w_mispredict;
  logic w_flush;

  assign full       = (r_count == c_depth);
  assign alloc_idx  = r_tail;
  assign jump_wrong = r_jump_wrong;
  assign jump_pc    = r_jump_pc;

  assign w_alloc      = rdy & disp_valid & ~full & ~r_jump_wrong;
  assign w_commit     = rdy & ~r_jump_wrong & r_busy[r_head] & r_ready[r_head];
  assign w_complete   = rdy & ~r_jump_wrong & cdb_valid & r_busy[cdb_idx];
  assign w_mispredict = w_commit & r_is_br[r_head] & (r_taken[r_head] != r_pred[r_head]);
  // Flush on the mispredicting commit edge so the buffer is already empty while
  // jump_wrong is high, and hold it empty through that cycle.
  assign w_flush      = w_mispredict | r_jump_wrong;

  assign rf_new_flag = w_alloc;
  assign rf_new_idx  = r_tail;
  assign rf_new_rd   = disp_rd;

  assign rf_write_flag = w_commit;
  assign rf_write_idx  = r_head;
  assign rf_write_rd   = r_rd[r_head];
  assign rf_write_val  = r_val[r_head];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_jump_wrong <= 1'b0;
      r_jump_pc    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_busy[i]  <= 1'b0;
        r_ready[i] <= 1'b0;
      end
    end else if (rdy) begin
      r_jump_wrong <= w_mispredict;
      if (w_mispredict) begin
        r_jump_pc <= r_target[r_head];
      end
      if (w_flush) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
        for (int i = 0; i < DEPTH; i++) begin
          r_busy[i]  <= 1'b0;
          r_ready[i] <= 1'b0;
        end
      end else begin
        if (w_complete) begin
          r_ready[cdb_idx] <= 1'b1;
        end
        if (w_commit) begin
          r_busy[r_head]  <= 1'b0;
          r_ready[r_head] <= 1'b0;
          r_head          <= r_head + c_idx_one;
        end
        if (w_alloc) begin
          r_busy[r_tail]  <= 1'b1;
          r_ready[r_tail] <= 1'b0;
          r_tail          <= r_tail + c_idx_one;
        end
        if (w_alloc && !w_commit) begin
          r_count <= r_count + c_cnt_one;
        end else if (!w_alloc && w_commit) begin
          r_count <= r_count - c_cnt_one;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_alloc) begin
      r_rd[r_tail]    <= disp_rd;
      r_is_br[r_tail] <= disp_is_br;
      r_pred[r_tail]  <= disp_pred_taken;
    end
    if (w_complete) begin
      r_val[cdb_idx]    <= cdb_val;
      r_taken[cdb_idx]  <= cdb_taken;
      r_target[cdb_idx] <= cdb_target;
    end
  end

  always_comb begin
    q1_ready = r_busy[q1_idx] & r_ready[q1_idx];
    q1_val   = r_val[q1_idx];
    q2_ready = r_busy[q2_idx] & r_ready[q2_idx];
    q2_val   = r_val[q2_idx];
`ifdef ROB_CDB_BYPASS_EN
    if (cdb_valid && (cdb_idx == q1_idx) && r_busy[q1_idx]) begin
      q1_ready = 1'b1;
      q1_val   = cdb_val;
    end
    if (cdb_valid && (cdb_idx == q2_idx) && r_busy[q2_idx]) begin
      q2_ready = 1'b1;
      q2_val   = cdb_val;
    end
`endif
  end

endmodule
`default_nettype wire

// File: tb/tb_rob.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_rob                                                          |
// | Purpose  : Self-checking bench for rob; commit scoreboard plus directed    |
// |            scenario tasks.                                                 |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_rob;
  localparam int DEPTH = 16;
  localparam int IDX_W = 4;

  logic             clk = 1'b0;
  logic             rst, rdy, disp_valid, disp_is_br, disp_pred_taken;
  logic [4:0]       disp_rd;
  logic [IDX_W-1:0] alloc_idx;
  logic             full;
  logic             cdb_valid, cdb_taken;
  logic [IDX_W-1:0] cdb_idx, q1_idx, q2_idx;
  logic [31:0]      cdb_val, cdb_target;
  logic             q1_ready, q2_ready;
  logic [31:0]      q1_val, q2_val;
  logic             rf_new_flag;
  logic [IDX_W-1:0] rf_new_idx;
  logic [4:0]       rf_new_rd;
  logic             rf_write_flag;
  logic [IDX_W-1:0] rf_write_idx;
  logic [4:0]       rf_write_rd;
  logic [31:0]      rf_write_val;
  logic             jump_wrong;
  logic [31:0]      jump_pc;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [4:0]       rd;
    logic [31:0]      val;
  } rec_t;

  rec_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  rob #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .disp_valid(disp_valid), .disp_rd(disp_rd), .disp_is_br(disp_is_br),
    .disp_pred_taken(disp_pred_taken), .alloc_idx(alloc_idx), .full(full),
    .cdb_valid(cdb_valid), .cdb_idx(cdb_idx), .cdb_val(cdb_val),
    .cdb_taken(cdb_taken), .cdb_target(cdb_target),
    .q1_idx(q1_idx), .q2_idx(q2_idx), .q1_ready(q1_ready), .q2_ready(q2_ready),
    .q1_val(q1_val), .q2_val(q2_val),
    .rf_new_flag(rf_new_flag), .rf_new_idx(rf_new_idx), .rf_new_rd(rf_new_rd),
    .rf_write_flag(rf_write_flag), .rf_write_idx(rf_write_idx),
    .rf_write_rd(rf_write_rd), .rf_write_val(rf_write_val),
    .jump_wrong(jump_wrong), .jump_pc(jump_pc)
  );

  always #5 clk = ~clk;

  // Commit monitor: every register-file write must match the oldest expected record.
  always begin
    @(negedge clk);
    #2;
    if (rf_write_flag === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL commit_unexpected: got idx %0d rd %0d val %0h, expected no commit",
                 rf_write_idx, rf_write_rd, rf_write_val);
      end else begin
        rec_t r;
        r = exp_q.pop_front();
        if ({rf_write_idx, rf_write_rd, rf_write_val} !== r) begin
          errors++;
          $display("FAIL commit_data: got idx %0d rd %0d val %0h, expected idx %0d rd %0d val %0h",
                   rf_write_idx, rf_write_rd, rf_write_val, r.idx, r.rd, r.val);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  task automatic do_reset(input logic rdy_during);
    @(negedge clk);
    rst = 1'b1; rdy = rdy_during; disp_valid = 1'b0; disp_rd = '0;
    disp_is_br = 1'b0; disp_pred_taken = 1'b0; cdb_valid = 1'b0; cdb_idx = '0;
    cdb_val = '0; cdb_taken = 1'b0; cdb_target = '0; q1_idx = '0; q2_idx = '0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0; rdy = 1'b1;
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    #1;
    checks++;
    if ({full, alloc_idx, rf_new_flag, rf_write_flag, q1_ready, q2_ready, jump_wrong} !== '0) begin
      errors++;
      $display("FAIL reset_ctrl: got full %0b alloc %0d new %0b write %0b q1 %0b q2 %0b jw %0b, expected all 0",
               full, alloc_idx, rf_new_flag, rf_write_flag, q1_ready, q2_ready, jump_wrong);
    end
    checks++;
    if (jump_pc !== 32'h0) begin
      errors++; $display("FAIL reset_jump_pc: got %0h expected 0", jump_pc);
    end
  endtask

  task automatic test_dispatch();
    @(negedge clk);
    disp_valid = 1'b1; disp_rd = 5'd5;
    exp_q.push_back('{idx: 4'd0, rd: 5'd5, val: 32'h1234});
    #1;
    checks++;
    if ({rf_new_flag, rf_new_idx, rf_new_rd} !== {1'b1, 4'd0, 5'd5}) begin
      errors++;
      $display("FAIL dispatch_new: got flag %0b idx %0d rd %0d expected 1 0 5",
               rf_new_flag, rf_new_idx, rf_new_rd);
    end
    @(negedge clk);
    disp_valid = 1'b0;
    #1;
    checks++;
    if (alloc_idx !== 4'd1) begin
      errors++; $display("FAIL dispatch_alloc_idx: got %0d expected 1", alloc_idx);
    end
  endtask

  task automatic test_commit();
    @(negedge clk);
    cdb_valid = 1'b1; cdb_idx = 4'd0; cdb_val = 32'h1234;
    #1;
    checks++;
    if (rf_write_flag !== 1'b0) begin
      errors++; $display("FAIL commit_same_cycle: got %0b expected 0", rf_write_flag);
    end
    @(negedge clk);
    cdb_valid = 1'b0;
    #1;
    checks++;
    if (rf_write_flag !== 1'b1) begin
      errors++; $display("FAIL commit_next_cycle: got %0b expected 1", rf_write_flag);
    end
  endtask

  task automatic test_out_of_order();
    @(negedge clk);
    disp_valid = 1'b1; disp_rd = 5'd1;
    exp_q.push_back('{idx: 4'd1, rd: 5'd1, val: 32'h11});
    @(negedge clk);
    disp_rd = 5'd2;
    exp_q.push_back('{idx: 4'd2, rd: 5'd2, val: 32'h22});
    @(negedge clk);
    disp_valid = 1'b0; cdb_valid = 1'b1; cdb_idx = 4'd2; cdb_val = 32'h22;
    @(negedge clk);
    cdb_valid = 1'b0; q1_idx = 4'd2;
    #1;
    checks++;
    if (rf_write_flag !== 1'b0) begin
      errors++; $display("FAIL ooo_blocked: got %0b expected 0", rf_write_flag);
    end
    checks++;
    if ({q1_ready, q1_val} !== {1'b1, 32'h22}) begin
      errors++; $display("FAIL ooo_lookup: got ready %0b val %0h expected 1 22", q1_ready, q1_val);
    end
    @(negedge clk);
    cdb_valid = 1'b1; cdb_idx = 4'd1; cdb_val = 32'h11;
    @(negedge clk);
    cdb_valid = 1'b0;
    #1;
    checks++;
    if (rf_write_flag !== 1'b1) begin
      errors++; $display("FAIL ooo_commit_first: got %0b expected 1", rf_write_flag);
    end
    @(negedge clk);
    #1;
    checks++;
    if (rf_write_flag !== 1'b1) begin
      errors++; $display("FAIL ooo_commit_second: got %0b expected 1", rf_write_flag);
    end
    @(negedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL ooo_drained: got %0d pending expected 0", exp_q.size());
    end
  endtask

  task automatic test_full();
    do_reset(1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      disp_valid = 1'b1; disp_rd = 5'(i + 1);
      exp_q.push_back('{idx: 4'(i), rd: 5'(i + 1), val: 32'hA000 + 32'(i)});
      #1;
      checks++;
      if ({rf_new_flag, rf_new_idx} !== {1'b1, 4'(i)}) begin
        errors++; $display("FAIL full_fill_%0d: got flag %0b idx %0d expected 1 %0d", i, rf_new_flag, rf_new_idx, i);
      end
    end
    @(negedge clk);
    disp_rd = 5'd30;
    #1;
    checks++;
    if ({full, rf_new_flag} !== 2'b10) begin
      errors++; $display("FAIL full_refuse: got full %0b new %0b expected 1 0", full, rf_new_flag);
    end
    @(negedge clk);
    disp_valid = 1'b0; cdb_valid = 1'b1; cdb_idx = 4'd0; cdb_val = 32'hA000;
    #1;
    checks++;
    if ({full, alloc_idx} !== {1'b1, 4'd0}) begin
      errors++; $display("FAIL full_tail_hold: got full %0b alloc %0d expected 1 0", full, alloc_idx);
    end
    @(negedge clk);
    cdb_valid = 1'b0; disp_valid = 1'b1; disp_rd = 5'd31;
    #1;
    checks++;
    if ({rf_write_flag, rf_new_flag} !== 2'b10) begin
      errors++; $display("FAIL full_commit_alloc: got write %0b new %0b expected 1 0", rf_write_flag, rf_new_flag);
    end
    @(negedge clk);
    disp_valid = 1'b0;
    #1;
    checks++;
    if ({full, alloc_idx} !== {1'b0, 4'd0}) begin
      errors++; $display("FAIL full_after_commit: got full %0b alloc %0d expected 0 0", full, alloc_idx);
    end
    for (int i = 1; i < DEPTH; i++) begin
      cdb_valid = 1'b1; cdb_idx = 4'(i); cdb_val = 32'hA000 + 32'(i);
      @(negedge clk);
    end
    cdb_valid = 1'b0;
    repeat (3) @(negedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL full_drained: got %0d pending expected 0", exp_q.size());
    end
  endtask

  task automatic test_bypass_and_hold();
    do_reset(1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      disp_valid = 1'b1; disp_rd = 5'(i + 1);
    end
    @(negedge clk);
    disp_valid = 1'b0; q1_idx = 4'd2; q2_idx = 4'd5;
    cdb_valid = 1'b1; cdb_idx = 4'd2; cdb_val = 32'd7;
    #1;
    checks++;
`ifdef ROB_CDB_BYPASS_EN
    if ({q1_ready, q1_val} !== {1'b1, 32'd7}) begin
      errors++; $display("FAIL bypass_same_cycle: got ready %0b val %0h expected 1 7", q1_ready, q1_val);
    end
`else
    if (q1_ready !== 1'b0) begin
      errors++; $display("FAIL nobypass_same_cycle: got ready %0b expected 0", q1_ready);
    end
`endif
    @(negedge clk);
    cdb_idx = 4'd5; cdb_val = 32'd9;
    #1;
    checks++;
    if ({q1_ready, q1_val, q2_ready} !== {1'b1, 32'd7, 1'b0}) begin
      errors++; $display("FAIL lookup_next_cycle: got q1 %0b/%0h q2 %0b expected 1/7 0", q1_ready, q1_val, q2_ready);
    end
    @(negedge clk);
    cdb_valid = 1'b0;
    #1;
    checks++;
    if (q2_ready !== 1'b0) begin
      errors++; $display("FAIL complete_not_busy: got %0b expected 0", q2_ready);
    end
    @(negedge clk);
    rdy = 1'b0; disp_valid = 1'b1; cdb_valid = 1'b1; cdb_idx = 4'd0; cdb_val = 32'd1;
    #1;
    checks++;
    if ({rf_new_flag, rf_write_flag} !== 2'b00) begin
      errors++; $display("FAIL hold_flags: got new %0b write %0b expected 0 0", rf_new_flag, rf_write_flag);
    end
    @(negedge clk);
    rdy = 1'b1; disp_valid = 1'b0; cdb_valid = 1'b0; q1_idx = 4'd0;
    #1;
    checks++;
    if ({q1_ready, alloc_idx, rf_write_flag} !== {1'b0, 4'd3, 1'b0}) begin
      errors++; $display("FAIL hold_state: got q1 %0b alloc %0d write %0b expected 0 3 0", q1_ready, alloc_idx, rf_write_flag);
    end
  endtask

  task automatic test_mispredict();
    do_reset(1'b1);
    @(negedge clk);
    disp_valid = 1'b1; disp_rd = 5'd0; disp_is_br = 1'b1; disp_pred_taken = 1'b0;
    exp_q.push_back('{idx: 4'd0, rd: 5'd0, val: 32'hAB});
    @(negedge clk);
    disp_rd = 5'd7; disp_is_br = 1'b0;
    @(negedge clk);
    disp_valid = 1'b0; cdb_valid = 1'b1; cdb_idx = 4'd0; cdb_val = 32'hAB;
    cdb_taken = 1'b1; cdb_target = 32'h100;
    @(negedge clk);
    cdb_valid = 1'b0; cdb_taken = 1'b0;
    #1;
    checks++;
    if ({rf_write_flag, jump_wrong} !== 2'b10) begin
      errors++; $display("FAIL br_commit: got write %0b jw %0b expected 1 0", rf_write_flag, jump_wrong);
    end
    @(negedge clk);
    disp_valid = 1'b1; disp_rd = 5'd9;
    #1;
    checks++;
    if ({jump_wrong, jump_pc} !== {1'b1, 32'h100}) begin
      errors++; $display("FAIL br_jump: got jw %0b pc %0h expected 1 100", jump_wrong, jump_pc);
    end
    checks++;
    if ({rf_new_flag, rf_write_flag, alloc_idx, full} !== {1'b0, 1'b0, 4'd0, 1'b0}) begin
      errors++; $display("FAIL br_flush: got new %0b write %0b alloc %0d full %0b expected 0 0 0 0",
                         rf_new_flag, rf_write_flag, alloc_idx, full);
    end
    @(negedge clk);
    disp_valid = 1'b0; q1_idx = 4'd1;
    #1;
    checks++;
    if ({jump_wrong, alloc_idx, q1_ready} !== {1'b0, 4'd0, 1'b0}) begin
      errors++; $display("FAIL br_after: got jw %0b alloc %0d q1 %0b expected 0 0 0", jump_wrong, alloc_idx, q1_ready);
    end
  endtask

  initial begin
    test_reset();
    test_dispatch();
    test_commit();
    test_out_of_order();
    test_full();
    test_bypass_and_hold();
    test_mispredict();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
